// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data wins by default; a starvation guard and a wait timeout bound latency.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err
);
    localparam int            SW      = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] SLIM    = SW'(STARVE_LIMIT);
    localparam logic [7:0]    TO_LAST = 8'(TIMEOUT - 1);
    localparam logic          TO_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DONE} state_t;

    state_t state_q, state_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              terr_q, terr_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [7:0]        wait_q, wait_d;

    logic pick_i;
    logic busy;
    logic live;
    logic fin_ok;
    logic fin_to;

    assign pick_i = if_req & (~d_req | (starve_q == SLIM));
    assign busy   = (state_q == BUSY_D) | (state_q == BUSY_I);
    assign live   = busy & mem_req_q;
    assign fin_ok = live & mem_ready;
    assign fin_to = live & ~mem_ready & TO_EN & (wait_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (if_req | d_req) state_d = pick_i ? BUSY_I : BUSY_D;
            end
            BUSY_D, BUSY_I: begin
                if (fin_ok | fin_to) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant edge latches the winner; the following BUSY cycle launches mem_req.
    always_comb begin
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        terr_d     = 1'b0;
        starve_d   = starve_q;
        wait_d     = wait_q;
        unique case (state_q)
            IDLE: begin
                if (!if_req) starve_d = '0;
                if (if_req | d_req) begin
                    mem_we_d = ~pick_i & d_we;
                    addr_d   = pick_i ? if_addr : d_addr;
                    wdata_d  = pick_i ? '0 : d_wdata;
                    wait_d   = '0;
                    if (pick_i) begin
                        starve_d = '0;
                    end else if (if_req && starve_q != SLIM) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            BUSY_D, BUSY_I: begin
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (fin_ok | fin_to) begin
                    mem_req_d = 1'b0;
                    terr_d    = fin_to;
                    if (state_q == BUSY_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = fin_ok ? mem_rdata : '0;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = fin_ok ? mem_rdata : '0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            terr_q     <= 1'b0;
            starve_q   <= '0;
            wait_q     <= '0;
        end else begin
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            terr_q     <= terr_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign timeout_err = terr_q;
    assign stall_if    = if_req & ~if_ack_q;
    assign stall_mem   = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus
// reset, starvation and back-to-back sequences against a latency memory model.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int cyc    = 0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if),
        .stall_mem(stall_mem),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers in the (lat+1)-th cycle mem_req is high; data = addr ^ 0x2002_0000.
    initial begin
        int hi;
        hi        = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            #1;
            hi        = mem_req ? hi + 1 : 0;
            mem_ready = mem_req && (hi == lat + 1);
            mem_rdata = mem_ready ? (mem_addr ^ 32'h2002_0000) : 32'hBAD0_BAD0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    typedef struct {
        logic        d_req;
        logic        d_we;
        logic        if_req;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] if_addr;
        int          lat;
        logic        exp_i;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
        int          exp_cyc;
        logic        exp_to;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        bit got;
        lat     = v.lat;
        d_req   = v.d_req;
        d_we    = v.d_we;
        d_addr  = v.d_addr;
        d_wdata = v.d_wdata;
        if_req  = v.if_req;
        if_addr = v.if_addr;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = mem_req;
        end
        chk($sformatf("v%0d mem_req_rise", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.exp_we));
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.exp_addr);
        if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.d_wdata);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            got = if_ack | d_ack;
        end
        chk($sformatf("v%0d ack_cycles", idx), 32'(n), 32'(v.exp_cyc));
        chk($sformatf("v%0d if_ack", idx), 32'(if_ack), 32'(v.exp_i));
        chk($sformatf("v%0d d_ack", idx), 32'(d_ack), 32'(!v.exp_i));
        chk($sformatf("v%0d mem_req_drop", idx), 32'(mem_req), 32'd0);
        chk($sformatf("v%0d timeout_err", idx), 32'(timeout_err), 32'(v.exp_to));
        chk($sformatf("v%0d rdata", idx), v.exp_i ? if_rdata : d_rdata, v.exp_rdata);
        chk($sformatf("v%0d stall_if", idx), 32'(stall_if), 32'(if_req && !v.exp_i));
        chk($sformatf("v%0d stall_mem", idx), 32'(stall_mem), 32'(d_req && v.exp_i));
        if (v.exp_i) if_req = 1'b0;
        else d_req = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d ack_pulse", idx), 32'({if_ack, d_ack, timeout_err}), 32'd0);
    endtask

    initial begin
        int   n;
        bit   got;
        int   t[3];
        logic [31:0] a;

        //      dreq  dwe   ireq  d_addr    d_wdata        if_addr   lat  exp_i exp_we exp_addr  exp_rdata      cyc  to
        tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h0,         32'h5,    2,   1'b1, 1'b0,  32'h5,    32'h2002_0005, 3,   1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h40,   32'hDEAD_BEEF, 32'h100,  0,   1'b0, 1'b1,  32'h40,   32'h0,         1,   1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h0,         32'h100,  0,   1'b1, 1'b0,  32'h100,  32'h2002_0100, 1,   1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h44,   32'h0,         32'h0,    1,   1'b0, 1'b0,  32'h44,   32'h2002_0044, 2,   1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h48,   32'h1234_5678, 32'h0,    3,   1'b0, 1'b1,  32'h48,   32'h2002_0044, 4,   1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h50,   32'h0,         32'h0,    100, 1'b0, 1'b0,  32'h50,   32'h0,         8,   1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,    32'h0,         32'h60,   100, 1'b1, 1'b0,  32'h60,   32'h0,         8,   1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h54,   32'h0,         32'h0,    7,   1'b0, 1'b0,  32'h54,   32'h2002_0054, 8,   1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h58,   32'hCAFE_F00D, 32'h0,    100, 1'b0, 1'b1,  32'h58,   32'h2002_0054, 8,   1'b1};

        rst_n   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst acks", 32'({if_ack, d_ack, timeout_err}), 32'd0);
        chk("rst if_rdata", if_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a data access.
        lat     = 100;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h80;
        d_wdata = 32'h5555_AAAA;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            got = mem_req;
        end
        chk("midrst mem_req_rise", 32'(got), 32'd1);
        chk("midrst mem_addr_live", mem_addr, 32'h80);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst mem_req", 32'(mem_req), 32'd0);
        chk("midrst mem_we", 32'(mem_we), 32'd0);
        chk("midrst mem_addr", mem_addr, 32'd0);
        chk("midrst mem_wdata", mem_wdata, 32'd0);
        chk("midrst acks", 32'({if_ack, d_ack, timeout_err}), 32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 9; k++) run_vec(k, tbl[k]);

        // Starvation guard: both requests held for six grants.
        lat     = 0;
        if_req  = 1'b1;
        if_addr = 32'h200;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h300;
        for (int g = 0; g < 6; g++) begin
            n   = 0;
            got = 1'b0;
            while (n < 40 && !got) begin
                @(posedge clk);
                #1;
                n++;
                got = if_ack | d_ack;
            end
            chk($sformatf("starve grant%0d", g), 32'({if_ack, d_ack}),
                (g == 4) ? 32'd2 : 32'd1);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait stream of three loads.
        lat    = 0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h400;
        for (int k = 0; k < 3; k++) begin
            n   = 0;
            got = 1'b0;
            while (n < 40 && !got) begin
                @(posedge clk);
                #1;
                n++;
                got = d_ack;
            end
            t[k] = cyc;
            a    = 32'h400 + 32'(4 * k);
            chk($sformatf("stream d_ack%0d", k), 32'(got), 32'd1);
            chk($sformatf("stream d_rdata%0d", k), d_rdata, a ^ 32'h2002_0000);
            d_addr = a + 32'd4;
        end
        d_req = 1'b0;
        chk("stream gap01", 32'(t[1] - t[0]), 32'd4);
        chk("stream gap12", 32'(t[2] - t[1]), 32'd4);
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
